// File: rtl/mem_access_pkg.sv
// Shared MIPS package: memory-access FSM encoding, default timeout
// and the request legality helper.
package mem_access_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int TIMEOUT_DEFAULT = 15;

   function automatic logic bad_req(
      input logic       rd,
      input logic       wr,
      input logic [1:0] lsb
   );
      return (rd & wr) | ((rd | wr) & (|lsb));
   endfunction

endpackage

// File: rtl/mem_access.sv
// Word load/store sequencer for the MIPS memory stage: one request,
// abort on timeout, MDR holds the last loaded word.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] ALUResult,
   input  logic [31:0] storeData,
   output logic [31:0] readData,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t        r_state;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         readData  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         fault     <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  mem_addr  <= ALUResult;
                  mem_wdata <= storeData;
                  busy      <= 1'b1;
                  fault     <= 1'b0;
                  if (bad_req(MemRead, MemWrite, ALUResult[1:0])) begin
                     r_state <= S_DONE;
                     done    <= 1'b1;
                     fault   <= 1'b1;
                  end else if (!MemRead && !MemWrite) begin
                     r_state <= S_DONE;
                     done    <= 1'b1;
                  end else begin
                     r_state <= S_REQ;
                     r_cnt   <= '0;
                     mem_req <= 1'b1;
                     mem_we  <= MemWrite;
                  end
               end
            end
            S_REQ: begin
               if (mem_ack) begin
                  if (!mem_we) readData <= mem_rdata;
                  r_state <= S_DONE;
                  done    <= 1'b1;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  // last allowed cycle expired with no ack: abort
                  if (r_cnt == LAST) begin
                     r_state <= S_DONE;
                     done    <= 1'b1;
                     fault   <= 1'b1;
                     mem_req <= 1'b0;
                     mem_we  <= 1'b0;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
